fanout_responder: RTL and testbench
===================================

# fanout_responder

Responder end of the dataflow req/ack protocol. Accepts words from a push-style source into a small FIFO and serves the head word to `output_size` requesters (async operator `req_l`/`ack_l` ports or consumers), each by a one-cycle `ack` pulse. A word is popped only after every requester has taken it. It sits between a producing stage and a fan-out of operators, decoupling them by `depth` words.

## Interface
Parameters:
- `data_width`, 32, word width
- `depth`, 4, FIFO entries; power of two, ≥2
- `output_size`, 2, number of requesters served per word, ≥1

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  source has a word on `in_data`
- `in_ready`  out  1  FIFO can accept a word this cycle
- `in_data`  in  `data_width`  pushed word
- `req`  in  `output_size`  per-requester request, level; bit j for requester j
- `ack`  out  `output_size`  per-requester one-cycle acknowledge
- `dout`  out  `data_width`  head word, shared by all requesters
- `count`  out  32  words popped since reset; only with `FANOUT_RESPONDER_COUNT_EN`

## Operation
- Push: `in_valid & in_ready` at an edge writes `in_data` at `wr_ptr`, `wr_ptr++` mod `depth`, occupancy +1.
- `in_ready` = occupancy < `depth`, combinational from registered occupancy. Occupancy width is clog2(`depth`)+1.
- `served[output_size-1:0]` register: bit j is set when requester j has received the current head word.
- Ack issue at an edge, per bit j: `ack[j] <= req[j] & ~ack[j] & ~served[j] & ~empty & ~(&served)`. When it fires, `served[j] <= 1` at the same edge. Otherwise `ack[j] <= 0`.
- Pop at an edge where `&served` is 1: `rd_ptr++` mod `depth`, occupancy −1, `served <= 0`, and no ack is issued at that edge.
- `dout` = `empty ? 0 : mem[rd_ptr]`. It is stable in every cycle where any `ack` bit is high.
- Requesters sample `dout` during their ack cycle, on the rising edge of `ack[j]`.
- Requesters may be acked in any order or together. A requester that is already served waits, with `req` held, until the pop.
- Simultaneous push and pop: both take effect and occupancy is unchanged. `in_ready` reflects pre-pop occupancy, so a full FIFO refuses the push in its pop cycle.
- Pointers wrap silently. Push is never accepted when full. Ack is never issued when empty.

## Timing
- Reset (`rst` low): `ack`=0, `in_ready`=0, `dout`=0, `count`=0. Pointers, occupancy and `served` are cleared immediately and asynchronously.
- Reset mid-operation: all buffered words and partial service are discarded and any asserted `ack` drops at once. After release, `in_ready`=1.
- Latency:
  - Word pushed at edge E can be acked at edge E+1 at the earliest. Its ack is high in cycle E+1..E+2.
  - Last ack at edge A triggers pop at edge A+1.
  - Next word's earliest ack is at edge A+2.
- Throughput with all `req` held high: one word per 2 cycles.
- `ack[j]` is never high on two consecutive cycles.
- `req[j]` dropping has no effect on a pulse already issued.

## Configuration
- `FANOUT_RESPONDER_COUNT_EN` defined: 32-bit `count` port exists.
  - Increments at each pop and wraps at 2^32.
  - Reset value 0.
- Not defined: the `count` port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `fanout_responder_pkg`:
  - `clog2` constant function.
  - Pointer and occupancy width localparams derived from `depth`.
- One sub-module `responder_fifo_mem`:
  - `depth` x `data_width` storage, not reset.
  - Write port (`we`, `waddr`, `wdata`) and combinational read at `raddr`.
- The top holds the pointers, occupancy, `served`, ack logic and `count`.

## Test plan
- Reset release, `output_size`=2, push 5 then 6, both `req` high:
  - Acks show 5 at E+1, pop.
  - Acks show 6 two cycles later.
  - `count`=2.
- Only `req[0]` high, FIFO holding 7:
  - `ack[0]` fires once with `dout`=7.
  - No further ack and no pop until `req[1]` rises.
  - `ack[1]` then shows 7 and pop follows.
- Push 1..4 with `depth`=4 and no `req`:
  - `in_ready` falls after the 4th push; a 5th push is refused.
  - Enabling both `req` yields 1,2,3,4 in order.
- Full FIFO, offer a push in the pop cycle:
  - Push is refused in that cycle and accepted in the next.
  - Occupancy returns to 4.
- Assert `rst` low while `ack[1]`=1 and 3 words are buffered:
  - `ack` drops immediately and `dout`=0.
  - After release, the first ack carries the first newly pushed word.
- `req` held high for 20 cycles on an empty FIFO: `ack` stays 0 throughout.

Source files
------------

// File: rtl/fanout_responder_pkg.sv
// Shared helpers for fanout_responder: clog2 and pointer/occupancy widths derived from depth.
package fanout_responder_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

  // One extra bit so that a full FIFO (occupancy == depth) is representable.
  function automatic int occ_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEPTH_DEF = 4;
  localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);
  localparam int OCC_W_DEF = occ_w(DEPTH_DEF);

endpackage

// File: rtl/responder_fifo_mem.sv
// Storage array for fanout_responder: one synchronous write port, combinational read.
module responder_fifo_mem
  import fanout_responder_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int aw         = ptr_w(depth)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [aw-1:0]         waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [aw-1:0]         raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [depth];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/fanout_responder.sv
// Responder end of the req/ack dataflow protocol: FIFO head word served to every requester
// before it is popped. Optional FANOUT_RESPONDER_COUNT_EN adds a 32-bit popped-word counter.
module fanout_responder
  import fanout_responder_pkg::*;
#(
  parameter int data_width  = 32,
  parameter int depth       = 4,
  parameter int output_size = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [data_width-1:0]  in_data,
  input  logic [output_size-1:0] req,
  output logic [output_size-1:0] ack,
  output logic [data_width-1:0]  dout
`ifdef FANOUT_RESPONDER_COUNT_EN
  ,
  output logic [31:0]            count
`endif
);

  localparam int PW = ptr_w(depth);
  localparam int OW = occ_w(depth);

  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [OW-1:0]          occ;
  logic [output_size-1:0] served, ack_fire;
  logic [data_width-1:0]  rdata;
  logic                   empty, all_served, push, pop;

  assign empty      = (occ == '0);
  assign all_served = &served;
  assign pop        = all_served;
  // Held low during reset so the source sees no space until release.
  assign in_ready   = rst & (occ < OW'(depth));
  assign push       = in_valid & in_ready;
  assign dout       = empty ? '0 : rdata;

  for (genvar j = 0; j < output_size; j++) begin : g_req
    assign ack_fire[j] = req[j] & ~ack[j] & ~served[j] & ~empty & ~all_served;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      served <= '0;
      ack    <= '0;
    end else begin
      ack <= ack_fire;
      if (pop) begin
        served <= '0;
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        served <= served | ack_fire;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      occ <= occ + OW'(push) - OW'(pop);
    end

`ifdef FANOUT_RESPONDER_COUNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst)     count <= '0;
    else if (pop) count <= count + 32'd1;
`endif

  responder_fifo_mem #(
    .data_width (data_width),
    .depth      (depth),
    .aw         (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fanout_responder.sv
// Directed self-checking bench for fanout_responder (depth 4, two requesters).
module tb_fanout_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  req;
  logic [1:0]  ack;
  logic [31:0] dout;
`ifdef FANOUT_RESPONDER_COUNT_EN
  logic [31:0] count;
`endif

  int checks   = 0;
  int failures = 0;
  int count_exp = 0;

  always #5 clk = ~clk;

  fanout_responder #(.data_width(32), .depth(4), .output_size(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .req      (req),
    .ack      (ack),
    .dout     (dout)
`ifdef FANOUT_RESPONDER_COUNT_EN
    ,
    .count    (count)
`endif
  );

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; req = '0;
    #3;
    checks++;
    if (ack !== 2'b00 || in_ready !== 1'b0 || dout !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: ack=%b in_ready=%b dout=%0d, want ack=00 in_ready=0 dout=0", ack, in_ready, dout);
    end
`ifdef FANOUT_RESPONDER_COUNT_EN
    checks++;
    if (count !== 32'd0) begin
      failures++;
      $display("FAIL reset_count: count=%0d want 0", count);
    end
`endif
    #10 rst = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    req = 2'b11; in_valid = 1'b1; in_data = 32'd5;
    step();
    in_data = 32'd6;
    step();
    in_valid = 1'b0;
    checks++;
    if (ack !== 2'b11 || dout !== 32'd5) begin
      failures++;
      $display("FAIL basic_ack5: ack=%b dout=%0d want ack=11 dout=5", ack, dout);
    end
    step();
    count_exp++;
    checks++;
    if (ack !== 2'b00 || dout !== 32'd6) begin
      failures++;
      $display("FAIL basic_pop5: ack=%b dout=%0d want ack=00 dout=6", ack, dout);
    end
    step();
    checks++;
    if (ack !== 2'b11 || dout !== 32'd6) begin
      failures++;
      $display("FAIL basic_ack6: ack=%b dout=%0d want ack=11 dout=6", ack, dout);
    end
    step();
    count_exp++;
    checks++;
    if (ack !== 2'b00 || dout !== 32'd0) begin
      failures++;
      $display("FAIL basic_pop6: ack=%b dout=%0d want ack=00 dout=0", ack, dout);
    end
`ifdef FANOUT_RESPONDER_COUNT_EN
    checks++;
    if (count !== 32'd2) begin
      failures++;
      $display("FAIL basic_count: count=%0d want 2", count);
    end
`endif
    req = 2'b00;
  endtask

  task automatic test_partial();
    in_valid = 1'b1; in_data = 32'd7;
    step();
    in_valid = 1'b0; req = 2'b01;
    step();
    checks++;
    if (ack !== 2'b01 || dout !== 32'd7) begin
      failures++;
      $display("FAIL partial_ack0: ack=%b dout=%0d want ack=01 dout=7", ack, dout);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ack !== 2'b00 || dout !== 32'd7) begin
        failures++;
        $display("FAIL partial_wait%0d: ack=%b dout=%0d want ack=00 dout=7", i, ack, dout);
      end
    end
    req = 2'b11;
    step();
    checks++;
    if (ack !== 2'b10 || dout !== 32'd7) begin
      failures++;
      $display("FAIL partial_ack1: ack=%b dout=%0d want ack=10 dout=7", ack, dout);
    end
    step();
    count_exp++;
    checks++;
    if (ack !== 2'b00 || dout !== 32'd0) begin
      failures++;
      $display("FAIL partial_pop: ack=%b dout=%0d want ack=00 dout=0", ack, dout);
    end
    req = 2'b00;
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      checks++;
      if (in_ready !== (i < 4)) begin
        failures++;
        $display("FAIL full_ready%0d: in_ready=%b want %0b", i, in_ready, (i < 4));
      end
    end
    in_data = 32'd99;
    step();
    in_valid = 1'b0; req = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (ack !== 2'b11 || dout !== 32'(i)) begin
        failures++;
        $display("FAIL full_drain%0d: ack=%b dout=%0d want ack=11 dout=%0d", i, ack, dout, i);
      end
      step();
      count_exp++;
    end
    step();
    checks++;
    if (ack !== 2'b00 || dout !== 32'd0) begin
      failures++;
      $display("FAIL full_refused: ack=%b dout=%0d want ack=00 dout=0", ack, dout);
    end
    req = 2'b00;
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'(10 + i);
      step();
    end
    in_valid = 1'b0; req = 2'b11;
    step();
    in_valid = 1'b1; in_data = 32'd14;
    #1;
    checks++;
    if (in_ready !== 1'b0 || ack !== 2'b11 || dout !== 32'd10) begin
      failures++;
      $display("FAIL fpp_popcycle: in_ready=%b ack=%b dout=%0d want 0 11 10", in_ready, ack, dout);
    end
    step();
    count_exp++;
    checks++;
    if (in_ready !== 1'b1 || ack !== 2'b00) begin
      failures++;
      $display("FAIL fpp_afterpop: in_ready=%b ack=%b want in_ready=1 ack=00", in_ready, ack);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || ack !== 2'b11 || dout !== 32'd11) begin
      failures++;
      $display("FAIL fpp_refill: in_ready=%b ack=%b dout=%0d want 0 11 11", in_ready, ack, dout);
    end
    step();
    count_exp++;
    for (int i = 12; i <= 14; i++) begin
      step();
      checks++;
      if (ack !== 2'b11 || dout !== 32'(i)) begin
        failures++;
        $display("FAIL fpp_drain%0d: ack=%b dout=%0d want ack=11 dout=%0d", i, ack, dout, i);
      end
      step();
      count_exp++;
    end
    checks++;
    if (dout !== 32'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fpp_empty: dout=%0d in_ready=%b want 0 1", dout, in_ready);
    end
`ifdef FANOUT_RESPONDER_COUNT_EN
    checks++;
    if (count !== 32'(count_exp)) begin
      failures++;
      $display("FAIL fpp_count: count=%0d want %0d", count, count_exp);
    end
`endif
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(20 + i);
      step();
    end
    in_valid = 1'b0; req = 2'b10;
    step();
    checks++;
    if (ack !== 2'b10 || dout !== 32'd20) begin
      failures++;
      $display("FAIL midrst_pre: ack=%b dout=%0d want ack=10 dout=20", ack, dout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ack !== 2'b00 || dout !== 32'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: ack=%b dout=%0d in_ready=%b want 00 0 0", ack, dout, in_ready);
    end
    #1 rst = 1'b1;
    req = 2'b00;
    count_exp = 0;
    step();
    checks++;
    if (in_ready !== 1'b1 || dout !== 32'd0 || ack !== 2'b00) begin
      failures++;
      $display("FAIL midrst_release: in_ready=%b dout=%0d ack=%b want 1 0 00", in_ready, dout, ack);
    end
    in_valid = 1'b1; in_data = 32'd30;
    step();
    in_valid = 1'b0; req = 2'b11;
    step();
    checks++;
    if (ack !== 2'b11 || dout !== 32'd30) begin
      failures++;
      $display("FAIL midrst_first: ack=%b dout=%0d want ack=11 dout=30", ack, dout);
    end
    step();
    count_exp++;
`ifdef FANOUT_RESPONDER_COUNT_EN
    checks++;
    if (count !== 32'(count_exp)) begin
      failures++;
      $display("FAIL midrst_count: count=%0d want %0d", count, count_exp);
    end
`endif
    req = 2'b00;
  endtask

  task automatic test_empty_req();
    int bad;
    bad = 0;
    req = 2'b11;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL empty_req: ack high in %0d of 20 cycles, want 0", bad);
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_full();
    test_full_pop_push();
    test_reset_mid();
    test_empty_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
